// File: rtl/yuv_rgb_pipeline.sv
// Purpose: streaming BT.601 YUV -> clamped RGB converter with pixel counting and end-of-frame tracking.
// Latency: 3 cycles from input transfer to out_valid (S1 offset, S2 multiply, S3 sum/shift/clamp); 1 pixel/cycle.
// Backpressure: all three stages freeze together while S3 holds an unaccepted pixel; in_ready = (~s3_valid | out_ready) & rst.
//
// Ports:
//   clk, rst                  rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready         input handshake; in_y/in_u/in_v unsigned PIX_W samples
//   out_valid/out_ready       output handshake; out_r/out_g/out_b clamped PIX_W samples
//   out_eof                   marks the last pixel of a frame (qualified by out_valid)
//   pix_cnt                   pixels already delivered in the current frame
//   frame_done                one-cycle pulse after the last pixel of a frame is accepted
// Optional: define CSC_FULL_RANGE_EN to add the full_range input, which selects JPEG
//   full-range coefficients per pixel (Yo = 0, unity luma gain).
module yuv_rgb_pipeline #(
  parameter int PIX_W        = 8,
  parameter int COEF_W       = 20,
  parameter int FRAC         = 16,
  parameter int FRAME_PIXELS = 76800,
  parameter int CNT_W        = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_y,
  input  logic [PIX_W-1:0] in_u,
  input  logic [PIX_W-1:0] in_v,
`ifdef CSC_FULL_RANGE_EN
  input  logic             full_range,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_r,
  output logic [PIX_W-1:0] out_g,
  output logic [PIX_W-1:0] out_b,
  output logic             out_eof,
  output logic [CNT_W-1:0] pix_cnt,
  output logic             frame_done
);

  // Widths: offset-removed samples, products, and sums with two guard bits.
  localparam int SW = PIX_W + 1;
  localparam int PW = COEF_W + PIX_W + 1;
  localparam int AW = PW + 2;
  localparam int SH = FRAC - 16;

  // Coefficients are tabulated at 2^16 and rescaled to the configured precision.
  localparam longint SCALE = longint'(1) << SH;

  localparam logic signed [COEF_W-1:0] CL_Y  = COEF_W'(longint'(76284) * SCALE);
  localparam logic signed [COEF_W-1:0] CL_RV = COEF_W'(longint'(104595) * SCALE);
  localparam logic signed [COEF_W-1:0] CL_GU = COEF_W'(longint'(-25624) * SCALE);
  localparam logic signed [COEF_W-1:0] CL_GV = COEF_W'(longint'(-53281) * SCALE);
  localparam logic signed [COEF_W-1:0] CL_BU = COEF_W'(longint'(132251) * SCALE);

`ifdef CSC_FULL_RANGE_EN
  localparam logic signed [COEF_W-1:0] CF_Y  = COEF_W'(longint'(65536) * SCALE);
  localparam logic signed [COEF_W-1:0] CF_RV = COEF_W'(longint'(91881) * SCALE);
  localparam logic signed [COEF_W-1:0] CF_GU = COEF_W'(longint'(-22554) * SCALE);
  localparam logic signed [COEF_W-1:0] CF_GV = COEF_W'(longint'(-46802) * SCALE);
  localparam logic signed [COEF_W-1:0] CF_BU = COEF_W'(longint'(116130) * SCALE);
`endif

  localparam logic signed [SW-1:0] YO_LIM = SW'(16 << (PIX_W - 8));
  localparam logic signed [SW-1:0] C_OFS  = SW'(1 << (PIX_W - 1));

  localparam logic signed [AW-1:0] PIX_MAX  = AW'((longint'(1) << PIX_W) - 1);
  localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(FRAME_PIXELS - 1);

  // ---------------------------------------------------------------------------
  // Flow control: one global advance enable, bubbles travel with the data.
  // ---------------------------------------------------------------------------
  logic adv;
  logic s1_vld_q, s2_vld_q, s3_vld_q;

  assign adv      = ~s3_vld_q | out_ready;
  assign in_ready = adv & rst;

  // ---------------------------------------------------------------------------
  // S1: remove luma/chroma offsets.
  // ---------------------------------------------------------------------------
  logic signed [SW-1:0] yo;
  logic signed [SW-1:0] ys_d, us_d, vs_d;
  logic signed [SW-1:0] ys_q, us_q, vs_q;
  logic                 fr_d, fr_q;

  always_comb begin
    yo   = YO_LIM;
    fr_d = 1'b0;
`ifdef CSC_FULL_RANGE_EN
    fr_d = full_range;
    if (full_range) begin
      yo = '0;
    end
`endif
    ys_d = $signed({1'b0, in_y}) - yo;
    us_d = $signed({1'b0, in_u}) - C_OFS;
    vs_d = $signed({1'b0, in_v}) - C_OFS;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld_q <= 1'b0;
      ys_q     <= '0;
      us_q     <= '0;
      vs_q     <= '0;
      fr_q     <= 1'b0;
    end else if (adv) begin
      s1_vld_q <= in_valid;
      ys_q     <= ys_d;
      us_q     <= us_d;
      vs_q     <= vs_d;
      fr_q     <= fr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // S2: the five non-zero products. The coefficient set follows the pixel, so
  // limited- and full-range pixels can sit next to each other in the pipe.
  // ---------------------------------------------------------------------------
  logic signed [COEF_W-1:0] c_y, c_rv, c_gu, c_gv, c_bu;
  logic signed [PW-1:0]     p_y_d, p_rv_d, p_gu_d, p_gv_d, p_bu_d;
  logic signed [PW-1:0]     p_y_q, p_rv_q, p_gu_q, p_gv_q, p_bu_q;

  always_comb begin
    c_y  = CL_Y;
    c_rv = CL_RV;
    c_gu = CL_GU;
    c_gv = CL_GV;
    c_bu = CL_BU;
`ifdef CSC_FULL_RANGE_EN
    if (fr_q) begin
      c_y  = CF_Y;
      c_rv = CF_RV;
      c_gu = CF_GU;
      c_gv = CF_GV;
      c_bu = CF_BU;
    end
`endif
    p_y_d  = PW'(ys_q) * PW'(c_y);
    p_rv_d = PW'(vs_q) * PW'(c_rv);
    p_gu_d = PW'(us_q) * PW'(c_gu);
    p_gv_d = PW'(vs_q) * PW'(c_gv);
    p_bu_d = PW'(us_q) * PW'(c_bu);
  end

  // Without the full-range option the S1 flag is constant; keep it observed.
  logic unused_fr;
  assign unused_fr = fr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_vld_q <= 1'b0;
      p_y_q    <= '0;
      p_rv_q   <= '0;
      p_gu_q   <= '0;
      p_gv_q   <= '0;
      p_bu_q   <= '0;
    end else if (adv) begin
      s2_vld_q <= s1_vld_q;
      p_y_q    <= p_y_d;
      p_rv_q   <= p_rv_d;
      p_gu_q   <= p_gu_d;
      p_gv_q   <= p_gv_d;
      p_bu_q   <= p_bu_d;
    end
  end

  // ---------------------------------------------------------------------------
  // S3: sum, floor-divide by 2^FRAC (arithmetic shift rounds toward -inf), clamp.
  // ---------------------------------------------------------------------------
  function automatic logic [PIX_W-1:0] clamp_pix(input logic signed [AW-1:0] acc);
    logic signed [AW-1:0] sh;
    logic [PIX_W-1:0]     res;
    sh = acc >>> FRAC;
    if (sh[AW-1]) begin
      res = '0;
    end else if (sh > PIX_MAX) begin
      res = '1;
    end else begin
      res = sh[PIX_W-1:0];
    end
    return res;
  endfunction

  logic signed [AW-1:0] sum_r, sum_g, sum_b;
  logic [PIX_W-1:0]     r_d, g_d, b_d;
  logic [PIX_W-1:0]     r_q, g_q, b_q;

  always_comb begin
    sum_r = AW'(p_y_q) + AW'(p_rv_q);
    sum_g = AW'(p_y_q) + AW'(p_gu_q) + AW'(p_gv_q);
    sum_b = AW'(p_y_q) + AW'(p_bu_q);
    r_d   = clamp_pix(sum_r);
    g_d   = clamp_pix(sum_g);
    b_d   = clamp_pix(sum_b);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s3_vld_q <= 1'b0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
    end else if (adv) begin
      s3_vld_q <= s2_vld_q;
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
    end
  end

  assign out_valid = s3_vld_q;
  assign out_r     = r_q;
  assign out_g     = g_q;
  assign out_b     = b_q;

  // ---------------------------------------------------------------------------
  // Frame tracking: count delivered pixels, wrap on the last one of a frame.
  // ---------------------------------------------------------------------------
  logic             out_xfer, last_pix;
  logic [CNT_W-1:0] pix_cnt_d, pix_cnt_q;
  logic             frame_done_d, frame_done_q;

  assign out_xfer = s3_vld_q & out_ready;
  assign last_pix = (pix_cnt_q == LAST_CNT);
  assign out_eof  = s3_vld_q & last_pix;

  always_comb begin
    pix_cnt_d    = pix_cnt_q;
    frame_done_d = 1'b0;
    if (out_xfer) begin
      if (last_pix) begin
        pix_cnt_d    = '0;
        frame_done_d = 1'b1;
      end else begin
        pix_cnt_d = pix_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      pix_cnt_q    <= pix_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign pix_cnt    = pix_cnt_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_yuv_rgb_pipeline.sv
// Directed bench for yuv_rgb_pipeline with a 5-pixel frame so end-of-frame
// handling is exercised quickly. Expected RGB values are hand-computed constants
// or come from an integer floor-division reference of the BT.601 equations.
module tb_yuv_rgb_pipeline;

  localparam int FP = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_eof, frame_done;
  logic [7:0]  in_y, in_u, in_v, out_r, out_g, out_b;
  logic [17:0] pix_cnt;
`ifdef CSC_FULL_RANGE_EN
  logic        full_range = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  logic [23:0] exp_q [$];
  int          n_out, n_eof, n_fd, mcnt, idx;
  bit          fd_exp, held_ok, acc;
  logic [24:0] held;

  logic [7:0] ty [10] = '{8'd16, 8'd50, 8'd100, 8'd235, 8'd255, 8'd0, 8'd128, 8'd200, 8'd81, 8'd180};
  logic [7:0] tu [10] = '{8'd128, 8'd90, 8'd50, 8'd128, 8'd10, 8'd0, 8'd200, 8'd60, 8'd240, 8'd128};
  logic [7:0] tv [10] = '{8'd128, 8'd240, 8'd200, 8'd128, 8'd250, 8'd0, 8'd30, 8'd100, 8'd16, 8'd64};

  yuv_rgb_pipeline #(
    .PIX_W(8), .COEF_W(20), .FRAC(16), .FRAME_PIXELS(FP), .CNT_W(18)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_y(in_y), .in_u(in_u), .in_v(in_v),
`ifdef CSC_FULL_RANGE_EN
    .full_range(full_range),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .out_eof(out_eof), .pix_cnt(pix_cnt), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Floor division by 2^16 then clamp to 8 bits.
  function automatic logic [7:0] cl(input longint n);
    longint q;
    q = n / 65536;
    if (n < 0 && (n % 65536) != 0) q = q - 1;
    if (q < 0) return 8'd0;
    if (q > 255) return 8'd255;
    return q[7:0];
  endfunction

  function automatic logic [23:0] model(input int y, input int u, input int v);
    longint ys, us, vs;
    ys = longint'(y) - 16;
    us = longint'(u) - 128;
    vs = longint'(v) - 128;
    return {cl(76284 * ys + 104595 * vs),
            cl(76284 * ys - 25624 * us - 53281 * vs),
            cl(76284 * ys + 132251 * us)};
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    n_out = 0; n_eof = 0; n_fd = 0; mcnt = 0;
    fd_exp = 1'b0; held_ok = 1'b0;
  endtask

  // Single isolated pixel: checks 3-cycle latency, value and eof flag.
  task automatic send1(input string tag, input logic [7:0] y, input logic [7:0] u,
                       input logic [7:0] v, input logic [23:0] e, input logic eof_e);
    in_valid = 1'b1; in_y = y; in_u = u; in_v = v;
    @(negedge clk); chk({tag, "_inrdy"}, in_ready, 1);
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk); chk({tag, "_lat1"}, out_valid, 0);
    @(posedge clk); #1;
    @(negedge clk); chk({tag, "_lat2"}, out_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_lat3"}, out_valid, 1);
    chk({tag, "_rgb"}, {out_r, out_g, out_b}, e);
    chk({tag, "_eof"}, out_eof, eof_e);
    @(posedge clk); #1;
  endtask

  // One streaming cycle: scoreboard, frame model, stall-hold checks.
  task automatic tick(output bit accepted);
    @(negedge clk);
    accepted = in_valid && in_ready;
    chk("fdone", frame_done, fd_exp);
    chk("eof", out_eof, out_valid && (mcnt == FP - 1));
    if (out_valid) chk("pixcnt", pix_cnt, mcnt);
    if (frame_done) n_fd++;
    if (out_valid && !out_ready) begin
      chk("stall_inrdy", in_ready, 0);
      if (held_ok) chk("stall_hold", {out_eof, out_r, out_g, out_b}, held);
      held = {out_eof, out_r, out_g, out_b};
      held_ok = 1'b1;
    end else begin
      held_ok = 1'b0;
    end
    fd_exp = 1'b0;
    if (out_valid && out_ready) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_out observed=extra expected=none");
      end
      if (exp_q.size() != 0) chk("rgb", {out_r, out_g, out_b}, exp_q.pop_front());
      n_out++;
      if (out_eof) n_eof++;
      if (mcnt == FP - 1) begin
        mcnt = 0;
        fd_exp = 1'b1;
      end else begin
        mcnt++;
      end
    end
    if (accepted) exp_q.push_back(model(in_y, in_u, in_v));
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_y = '0; in_u = '0; in_v = '0;

    // Reset state
    @(negedge clk);
    chk("rst_ovld", out_valid, 0);
    chk("rst_cnt", pix_cnt, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_inrdy", in_ready, 0);
    chk("rst_rgb", {out_r, out_g, out_b}, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk); chk("rel_inrdy", in_ready, 1);
    @(posedge clk); #1;

    // Isolated pixels: black, near-white, clamped white, saturated red, all-zero input.
    send1("t1_black", 8'd16, 8'd128, 8'd128, 24'h000000, 1'b0);
    send1("t2_white", 8'd235, 8'd128, 8'd128, 24'hFEFEFE, 1'b0);
    send1("t2_clamp", 8'd255, 8'd128, 8'd128, 24'hFFFFFF, 1'b0);
    send1("t3_red", 8'd16, 8'd128, 8'd255, 24'hCA0000, 1'b0);
    chk("t3_cnt4", pix_cnt, 4);
    send1("t3_zero", 8'd0, 8'd0, 8'd0, 24'h008700, 1'b1);
    @(negedge clk);
    chk("t3_fd_pulse", frame_done, 1);
    chk("t3_cnt_wrap", pix_cnt, 0);
    @(posedge clk); #1;
    @(negedge clk); chk("t3_fd_low", frame_done, 0);
    @(posedge clk); #1;

    // Stream 10 pixels with a 4-cycle downstream stall mid-stream.
    do_reset();
    idx = 0;
    for (int c = 0; c < 60 && n_out < 10; c++) begin
      out_ready = !(c >= 5 && c < 9);
      if (idx < 10) begin
        in_valid = 1'b1; in_y = ty[idx]; in_u = tu[idx]; in_v = tv[idx];
      end else begin
        in_valid = 1'b0;
      end
      tick(acc);
      if (acc) idx++;
    end
    chk("t4_nout", n_out, 10);
    chk("t4_qempty", exp_q.size(), 0);
    chk("t4_cnt", pix_cnt, 0);

    // 12 pixels across frame boundaries.
    do_reset();
    out_ready = 1'b1;
    idx = 0;
    for (int c = 0; c < 60 && n_out < 12; c++) begin
      if (idx < 12) begin
        in_valid = 1'b1; in_y = ty[idx % 10]; in_u = tu[idx % 10]; in_v = tv[(idx + 3) % 10];
      end else begin
        in_valid = 1'b0;
      end
      tick(acc);
      if (acc) idx++;
    end
    tick(acc);
    chk("t5_nout", n_out, 12);
    chk("t5_neof", n_eof, 2);
    chk("t5_nfd", n_fd, 2);
    chk("t5_cnt", pix_cnt, 2);

    // Reset with three pixels stalled in flight.
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_y = ty[k]; in_u = tu[k]; in_v = tv[k];
      @(negedge clk); chk("t6_acc", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("t6_full", out_valid, 1);
    chk("t6_stall_rdy", in_ready, 0);
    #1 rst = 1'b0;
    #1;
    chk("t6_ovld", out_valid, 0);
    chk("t6_cnt", pix_cnt, 0);
    chk("t6_fd", frame_done, 0);
    chk("t6_inrdy", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("t6_rel_inrdy", in_ready, 1);
    chk("t6_rel_ovld", out_valid, 0);
    @(posedge clk); #1;
    send1("t6_fresh", 8'd100, 8'd50, 8'd200, 24'hD44500, 1'b0);
    @(negedge clk); chk("t6_cnt1", pix_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/yuv_rgb_pipeline.md
Name: yuv_rgb_pipeline

Overview:
Streaming, fully pipelined YUV-to-RGB colour converter for the colour-conversion path.
- Accepts one YUV pixel per beat over a valid/ready handshake and emits one clamped RGB pixel per beat.
- Counts pixels and flags end-of-frame.
- Generalises the single-lane fixed 8-bit converter: parametrised sample width, coefficient precision and frame size; backpressure support; frame tracking.

Parameters:
PIX_W, 8, sample width of Y/U/V in and R/G/B out (>= 8)
COEF_W, 20, signed coefficient width
FRAC, 16, fractional bits of coefficients (1.0 = 2^FRAC)
FRAME_PIXELS, 76800, pixels per frame
CNT_W, 18, pixel counter width (2^CNT_W >= FRAME_PIXELS)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
in_valid  in  1  input pixel valid
in_ready  out  1  converter can accept input this cycle
in_y / in_u / in_v  in  PIX_W each  unsigned samples
out_valid  out  1  output pixel valid
out_ready  in  1  downstream accepts output
out_r / out_g / out_b  out  PIX_W each  clamped RGB
out_eof  out  1  qualifies last pixel of frame (valid with out_valid)
pix_cnt  out  CNT_W  pixels already delivered in current frame
frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Coefficients are localparams (BT.601 limited range, scaled 2^16 at FRAC=16, shifted left by FRAC-16 otherwise):
  - Y: 76284.
  - R: V 104595.
  - G: U -25624, V -53281.
  - B: U 132251.
- Offsets: Yo = 16<<(PIX_W-8); Co = 1<<(PIX_W-1).
- Pipeline, 3 register stages, each with its own valid bit:
  - S1: ys = Y-Yo, us = U-Co, vs = V-Co; signed, PIX_W+1 bits.
  - S2: the five non-zero products; signed, COEF_W+PIX_W+1 bits.
  - S3: per channel, sum the products (+2 guard bits), then arithmetic shift right by FRAC (floor, not truncate-toward-zero). Clamp: <0 -> 0; >2^PIX_W-1 -> 2^PIX_W-1.
- Stall rule: adv = ~s3_valid | out_ready; in_ready = adv & rst. All stages shift together when adv=1; bubbles are not compressed.
- Transfer: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
- Latency: exactly 3 cycles from input transfer to out_valid when out_ready is held high. Throughput: 1 pixel/cycle.
- While out_valid=1 and out_ready=0, out_r/g/b/out_eof are held stable and no new pixel is accepted.
- pix_cnt increments on each output transfer.
  - out_eof = out_valid & (pix_cnt == FRAME_PIXELS-1).
  - On the transfer with out_eof=1: pix_cnt wraps to 0 and frame_done pulses high on the next cycle only.
- Reset (asynchronous, any time, including mid-frame or mid-stall):
  - All valids, data registers, pix_cnt and frame_done go to 0; in_ready is 0 while rst=0.
  - In-flight pixels are discarded; the first cycle after release has in_ready=1.
- in_valid with no ready: no state change upstream. in_valid=0 with adv=1 shifts a bubble into S1.

Optional Feature:
CSC_FULL_RANGE_EN
- Defined:
  - Adds input port full_range (1 bit), captured into S1 with each pixel and carried down the pipeline.
  - full_range=1 selects JPEG full-range coefficients: Yo=0, Y coefficient = 1.0 (65536), R_V 91881, G_U -22554, G_V -46802, B_U 116130 (scaled as above).
  - Mixed-mode pixels may be adjacent in the pipeline.
- Undefined: the port is absent and only limited-range coefficients exist.

Test Plan:
1. Y=16,U=128,V=128, out_ready=1 -> RGB (0,0,0), out_valid exactly 3 cycles after the input transfer.
2. Y=235,U=V=128 -> (254,254,254); Y=255,U=V=128 -> (255,255,255) via clamp.
3. Y=16,U=128,V=255 -> (202,0,0): G floor of -103.25 gives -104, clamped to 0. Y=0,U=0,V=0 -> (0,135,0).
4. Stream 10 pixels, drop out_ready for 4 cycles mid-stream -> outputs held stable, in_ready=0 during the stall, no loss or duplication, order preserved.
5. FRAME_PIXELS=5, stream 12 pixels -> out_eof on pixels 5 and 10; pix_cnt wraps to 0; frame_done one-cycle pulse after each; pix_cnt=2 at the end.
6. Assert rst low with 3 pixels in flight and out_ready=0 -> out_valid, pix_cnt, frame_done are 0 immediately. After release, a fresh pixel emerges after 3 cycles with a correct value.
